counter_alarm: RTL

Compare/alarm unit that sits directly downstream of the 64-bit free-running counter. It consumes the counter's `count` output and raises an alarm when the count reaches a programmed compare value. It supports one-shot and periodic (auto-reload) modes, a level interrupt with acknowledge, and a saturating missed-event counter. The block is the timer-interrupt source for the software-visible timer subsystem.

---
 rtl/counter_alarm.sv | 102 ++++++++++
 1 files changed

// File: rtl/counter_alarm.sv
// counter_alarm: compare/alarm unit fed by a free-running counter.
// One-shot or periodic alarm, level irq with ack, saturating miss counter. Rev 1.0
`default_nettype none

module counter_alarm #(
  parameter int WIDTH  = 64,
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count,
  input  logic              cfg_wen,
  input  logic [WIDTH-1:0]  cfg_cmp,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic              cfg_periodic,
  input  logic              arm,
  input  logic              disarm,
  input  logic              irq_ack,
  output logic              irq,
  output logic              alarm_pulse,
  output logic [1:0]        state,
  output logic [WIDTH-1:0]  next_cmp,
  output logic [MISS_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    FIRED = 2'b10
  } state_t;

  localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

  state_t             cur_state, state_d;
  logic [WIDTH-1:0]   shadow_cmp, shadow_period;
  logic               shadow_periodic;
  logic [WIDTH-1:0]   cmp_d;
  logic [WIDTH-1:0]   diff;
  logic               hit, take_hit, reload;
  logic               irq_d;
  logic [MISS_W-1:0]  miss_d;

  // Wrap-safe "reached or passed by less than half the range" test.
  assign diff     = count - next_cmp;
  assign hit      = (cur_state == ARMED) && !diff[WIDTH-1];
  assign take_hit = hit && !disarm && !arm;
  assign reload   = shadow_periodic && (shadow_period != '0);
  assign state    = cur_state;

  always_comb begin
    state_d = cur_state;
    cmp_d   = next_cmp;
    irq_d   = irq;
    miss_d  = miss_cnt;

    if (disarm) begin
      state_d = IDLE;
    end else if (arm) begin
      state_d = ARMED;
      cmp_d   = shadow_cmp;
    end else if (hit) begin
      if (reload) cmp_d = next_cmp + shadow_period;
      else        state_d = FIRED;
    end

    if (take_hit)     irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;

    // A fresh arm with nothing pending starts the miss history over.
    if (arm && !disarm && !irq)
      miss_d = '0;
    else if (take_hit && irq && !irq_ack && (miss_cnt != '1))
      miss_d = miss_cnt + MISS_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state       <= IDLE;
      next_cmp        <= '0;
      irq             <= 1'b0;
      alarm_pulse     <= 1'b0;
      miss_cnt        <= '0;
      shadow_cmp      <= '0;
      shadow_period   <= '0;
      shadow_periodic <= 1'b0;
    end else begin
      cur_state   <= state_d;
      next_cmp    <= cmp_d;
      irq         <= irq_d;
      alarm_pulse <= take_hit;
      miss_cnt    <= miss_d;
      if (cfg_wen) begin
        shadow_cmp      <= cfg_cmp;
        shadow_period   <= cfg_period;
        shadow_periodic <= cfg_periodic;
      end
    end
  end

endmodule

`default_nettype wire
